// File: rtl/disp_addr_gen_pkg.sv
// Shared types and constants for the display read-address generator.
// The coordinate type is wide enough for mirrored, zoomed and panned
// positions, including negative values produced by a negative pan.
package disp_addr_gen_pkg;

   typedef logic signed [11:0] coord_t;

   // Switch bit positions inside the per-frame snapshot
   localparam int SW_HMIR    = 0;
   localparam int SW_VMIR    = 1;
   localparam int SW_ZOOM    = 2;
   localparam int SW_PANX_LO = 4;
   localparam int SW_PANX_HI = 9;
   localparam int SW_PANY_LO = 10;
   localparam int SW_PANY_HI = 15;
   localparam int SNAP_W     = 16;

   // One pan step moves the source window by this many pixels
   localparam coord_t PAN_SCALE = 12'sd8;

   // Bit of the output word that flags an in-range source pixel
   localparam int ADDR_VALID_BIT = 19;

   // Sign-extend a 6-bit pan field and scale it to pixels
   function automatic coord_t pan_offset(input logic [5:0] pan);
      coord_t ext;
      ext = coord_t'(signed'(pan));
      return ext * PAN_SCALE;
   endfunction

endpackage

// File: rtl/disp_addr_gen_raster_counter.sv
// Raster position counter: DX runs across a line, DY advances on the line
// wrap and returns to 0 after the last line. Both hold when en is low.
module raster_counter
   import disp_addr_gen_pkg::*;
#(
   parameter int WIDTH  = 800,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [11:0] dx,
   output logic [11:0] dy,
   output logic        line_wrap,
   output logic        frame_start
);

   localparam coord_t X_LAST = coord_t'(WIDTH - 1);
   localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);

   coord_t dx_q, dx_d;
   coord_t dy_q, dy_d;

   assign line_wrap   = (dx_q == X_LAST);
   assign frame_start = (dx_q == 12'sd0) && (dy_q == 12'sd0);
   assign dx          = dx_q;
   assign dy          = dy_q;

   // Next raster position: step DX, wrap it and step DY at end of line
   always_comb begin
      dx_d = dx_q;
      dy_d = dy_q;
      if (en) begin
         if (line_wrap) begin
            dx_d = 12'sd0;
            if (dy_q == Y_LAST) begin
               dy_d = 12'sd0;
            end else begin
               dy_d = dy_q + 12'sd1;
            end
         end else begin
            dx_d = dx_q + 12'sd1;
            dy_d = dy_q;
         end
      end else begin
         dx_d = dx_q;
         dy_d = dy_q;
      end
   end

   // Position registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dx_q <= 12'sd0;
         dy_q <= 12'sd0;
      end else begin
         dx_q <= dx_d;
         dy_q <= dy_d;
      end
   end

endmodule

// File: rtl/disp_addr_gen.sv
// Display-side SRAM read-address generator. Walks the display raster and
// applies mirror, optional 2x centred zoom and pan, producing one address
// per pixel through a 3-stage pipeline that stalls as a whole.
// Build option: define DISP_ADDR_GEN_ZOOM_EN to include the zoom path
// (iSW[2]); without it the zoom switch is ignored.
module disp_addr_gen
   import disp_addr_gen_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = 800,
   parameter int DISPLAY_HEIGHT = 480,
   parameter int INPUT_WIDTH    = 800,
   parameter int INPUT_HEIGHT   = 480
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        iREAD,
   input  logic [17:0] iSW,
   output logic [19:0] oADDRESS,
   output logic        oREADY_N
);

   localparam coord_t      DW_LAST = coord_t'(DISPLAY_WIDTH - 1);
   localparam coord_t      DH_LAST = coord_t'(DISPLAY_HEIGHT - 1);
   localparam coord_t      IW_C    = coord_t'(INPUT_WIDTH);
   localparam coord_t      IH_C    = coord_t'(INPUT_HEIGHT);
   localparam logic [18:0] IW_ADDR = 19'(INPUT_WIDTH);
`ifdef DISP_ADDR_GEN_ZOOM_EN
   localparam coord_t      ZOOM_X_OFF = coord_t'(DISPLAY_WIDTH / 4);
   localparam coord_t      ZOOM_Y_OFF = coord_t'(DISPLAY_HEIGHT / 4);
`endif

   // Pipeline registers
   logic              v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
   coord_t            dx1_q, dx1_d, dy1_q, dy1_d;
   logic [SNAP_W-1:0] sw1_q, sw1_d, snap_q, snap_d;
   coord_t            sx2_q, sx2_d, sy2_q, sy2_d;
   logic [19:0]       addr_q, addr_d;

   // Combinational helpers
   logic              advance_s;
   logic [11:0]       rc_dx_s, rc_dy_s;
   logic              line_wrap_s, frame_start_s;
   logic [SNAP_W-1:0] sw_in_s;
   coord_t            mx_s, my_s, sx_pre_s, sy_pre_s;
   logic              in_range_s;
   logic [18:0]       addr_lin_s;
   logic              unused_s;

   // The whole pipeline moves when the output is empty or being consumed
   assign advance_s = ~out_valid_q | iREAD;

   raster_counter #(
      .WIDTH  (DISPLAY_WIDTH),
      .HEIGHT (DISPLAY_HEIGHT)
   ) u_raster (
      .clk         (CLK),
      .rst_n       (RESET_N),
      .en          (advance_s),
      .dx          (rc_dx_s),
      .dy          (rc_dy_s),
      .line_wrap   (line_wrap_s),
      .frame_start (frame_start_s)
   );

   // Stage 1 input: pixel (0,0) takes fresh switches, others reuse the snapshot
   always_comb begin
      sw_in_s = snap_q;
      if (frame_start_s) begin
         sw_in_s = iSW[SNAP_W-1:0];
      end else begin
         sw_in_s = snap_q;
      end
   end

   // Stage 2 transform: mirror, optional zoom, then pan
   always_comb begin
      mx_s     = dx1_q;
      my_s     = dy1_q;
      sx_pre_s = dx1_q;
      sy_pre_s = dy1_q;
      if (sw1_q[SW_HMIR]) begin
         mx_s = DW_LAST - dx1_q;
      end else begin
         mx_s = dx1_q;
      end
      if (sw1_q[SW_VMIR]) begin
         my_s = DH_LAST - dy1_q;
      end else begin
         my_s = dy1_q;
      end
`ifdef DISP_ADDR_GEN_ZOOM_EN
      if (sw1_q[SW_ZOOM]) begin
         sx_pre_s = (mx_s >>> 1) + ZOOM_X_OFF;
         sy_pre_s = (my_s >>> 1) + ZOOM_Y_OFF;
      end else begin
         sx_pre_s = mx_s;
         sy_pre_s = my_s;
      end
`else
      sx_pre_s = mx_s;
      sy_pre_s = my_s;
`endif
   end

   // Stage 3 range check and row-major address
   always_comb begin
      in_range_s = (sx2_q >= 12'sd0) && (sx2_q < IW_C) &&
                   (sy2_q >= 12'sd0) && (sy2_q < IH_C);
      addr_lin_s = 19'(sy2_q) * IW_ADDR + 19'(sx2_q);
   end

   // Next-state for every pipeline register; everything holds on a stall
   always_comb begin
      v1_d        = v1_q;
      dx1_d       = dx1_q;
      dy1_d       = dy1_q;
      sw1_d       = sw1_q;
      snap_d      = snap_q;
      v2_d        = v2_q;
      sx2_d       = sx2_q;
      sy2_d       = sy2_q;
      out_valid_d = out_valid_q;
      addr_d      = addr_q;
      if (advance_s) begin
         v1_d        = 1'b1;
         dx1_d       = $signed(rc_dx_s);
         dy1_d       = $signed(rc_dy_s);
         sw1_d       = sw_in_s;
         snap_d      = sw_in_s;
         v2_d        = v1_q;
         sx2_d       = sx_pre_s + pan_offset(sw1_q[SW_PANX_HI:SW_PANX_LO]);
         sy2_d       = sy_pre_s + pan_offset(sw1_q[SW_PANY_HI:SW_PANY_LO]);
         out_valid_d = v2_q;
         if (v2_q && in_range_s) begin
            addr_d                 = {1'b0, addr_lin_s};
            addr_d[ADDR_VALID_BIT] = 1'b1;
         end else begin
            addr_d = 20'd0;
         end
      end else begin
         v1_d = v1_q;
      end
   end

   // Pipeline, snapshot and output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         v1_q        <= 1'b0;
         dx1_q       <= 12'sd0;
         dy1_q       <= 12'sd0;
         sw1_q       <= 16'd0;
         snap_q      <= 16'd0;
         v2_q        <= 1'b0;
         sx2_q       <= 12'sd0;
         sy2_q       <= 12'sd0;
         out_valid_q <= 1'b0;
         addr_q      <= 20'd0;
      end else begin
         v1_q        <= v1_d;
         dx1_q       <= dx1_d;
         dy1_q       <= dy1_d;
         sw1_q       <= sw1_d;
         snap_q      <= snap_d;
         v2_q        <= v2_d;
         sx2_q       <= sx2_d;
         sy2_q       <= sy2_d;
         out_valid_q <= out_valid_d;
         addr_q      <= addr_d;
      end
   end

   assign oADDRESS = addr_q;
   assign oREADY_N = ~out_valid_q;

`ifdef DISP_ADDR_GEN_ZOOM_EN
   assign unused_s = ^{iSW[17:16], sw1_q[3], line_wrap_s};
`else
   assign unused_s = ^{iSW[17:16], sw1_q[3], sw1_q[SW_ZOOM], line_wrap_s};
`endif

endmodule

// File: doc/disp_addr_gen.md
# disp_addr_gen

Display-side read-address generator for the LTM video path. It walks the display raster and applies a switch-selected geometric transform: mirror, optional 2x centred zoom, and pan. It emits one SRAM frame-buffer address per display pixel, with an in-range flag in bit 19. It sits directly upstream of the SRAM controller, which pops addresses with a one-cycle read strobe and blanks out-of-range pixels.

## Interface
- DISPLAY_WIDTH, 800, display pixels per line
- DISPLAY_HEIGHT, 480, display lines per frame
- INPUT_WIDTH, 800, stored image width (SRAM row pitch)
- INPUT_HEIGHT, 480, stored image height
- CLK  in  1  single clock; all logic on rising edge
- RESET_N  in  1  reset, asynchronous assert, active-low
- iREAD  in  1  pop strobe; consumes the current address when oREADY_N=0
- iSW  in  18  switches: [0] H-mirror, [1] V-mirror, [2] 2x zoom, [9:4] signed X pan, [15:10] signed Y pan (pan units of 8 px); other bits ignored
- oADDRESS  out  20  [19]=1 source pixel in range; [18:0] SRAM word address (0 when [19]=0)
- oREADY_N  out  1  0 = oADDRESS holds a valid, unconsumed address

## Operation
- Raster counters: DX counts 0..DISPLAY_WIDTH-1; DY increments when DX wraps, counting 0..DISPLAY_HEIGHT-1, then wraps to 0. Counters advance only when a pixel enters the pipeline.
- Switch snapshot: iSW[15:0] is registered only when pixel (0,0) enters stage 1, so a frame always uses consistent settings. Mid-frame switch changes take effect from the next frame. At reset the snapshot is 0 (identity).
- Transform, all arithmetic signed 12-bit:
  - Mirror: mx = H ? DISPLAY_WIDTH-1-DX : DX; my likewise with V.
  - Zoom: sx = Z ? mx/2 + DISPLAY_WIDTH/4 : mx; sy likewise with DISPLAY_HEIGHT/4.
  - Pan: sx += sext(pan_x)*8; sy += sext(pan_y)*8.
- Range check: valid = 0≤sx<INPUT_WIDTH and 0≤sy<INPUT_HEIGHT.
- Address: valid ? sy*INPUT_WIDTH+sx (19 bits) : 0, with bit19 = valid.
- Pipeline, 3 stages: S1 registers coordinates plus the snapshot, S2 registers the transform result, S3 is the multiply-add/range check into the output register.
  - Each stage carries a valid bit.
  - Global advance = ~out_valid | iREAD. All stages stall together when advance = 0.
- Handshake:
  - iREAD while oREADY_N=1 is ignored.
  - iREAD while oREADY_N=0 consumes the current address. The next address (if S2 is valid) appears the following cycle with oREADY_N staying 0, giving back-to-back throughput of 1 per cycle.
  - oADDRESS is stable while oREADY_N=0 and no iREAD occurs.
- Reset, including mid-frame:
  - All valids cleared, counters at (0,0), snapshot 0.
  - oADDRESS=0, oREADY_N=1.
  - After release, the frame restarts at pixel (0,0).

## Timing
- Latency: the first address is valid (oREADY_N=0) on the 3rd rising edge after RESET_N deasserts.
- With the pipeline full and iREAD held high, a new address is delivered every cycle with no bubbles, including at line wrap and frame wrap.
- A stall of any length loses and duplicates no pixel.
- The snapshot update and the DX/DY wrap occur in the same cycle without conflict.

## Configuration
- DISP_ADDR_GEN_ZOOM_EN defined: the zoom path is compiled in and honours iSW[2].
- Undefined: the zoom logic is removed, iSW[2] is ignored, and sx=mx, sy=my before pan.
- Mirror and pan are always present.

## Structure
- Shared package holds:
  - The coordinate typedef (signed 12-bit).
  - Switch-bit index constants (SW_HMIR=0, SW_VMIR=1, SW_ZOOM=2, pan field bounds).
  - The pan scale constant (8).
  - The address-valid bit index (19).
- Sub-module raster_counter:
  - DX/DY counters with an enable input.
  - Outputs: line-wrap and frame-start indications.
- The top level holds the snapshot, transform, multiply, and valid pipeline.

## Test plan
- Reset, then hold iREAD=1: the first address is 0x80000 on edge 3, then 0x80001, and so on. After 799 comes 800 (0x80320) at the line wrap. After 384000 pops the sequence returns to 0x80000.
- iSW[0]=1 from reset: the first address is 0x8031F (799), decrementing to 0x80000, then the next line starts at 0x8063F (1599).
- iSW[2]=1 with the macro defined: the first two addresses are both 0x977C8 (96200). The macro undefined with the same stimulus gives 0x80000, 0x80001.
- iSW[9:4]=6'h3F (pan -8): the first 8 addresses of each line are 0x00000 (invalid), then 0x80000.
- Switch change mid-frame plus random iREAD stalls: the output stays unchanged while stalled, no pixel is skipped, and the new transform appears only from pixel (0,0) of the next frame.
- RESET_N pulse mid-line: oREADY_N=1 and oADDRESS=0 immediately. After release the sequence restarts at 0x80000 with latency 3.
